// File: rtl/fetch_queue.sv
// Fetch queue: first-word-fall-through FIFO of PC/instruction pairs between
// the fetch and decode stages. A redirect (flush) empties it in one edge.
// Pushes with a misaligned PC are dropped and reported by a sticky flag.
module fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_instr,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       misalign_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             misalign_q;

    logic             pc_aligned;
    logic             push_try;
    logic             do_push;
    logic             do_pop;
    logic             bad_push;

    // Status outputs and the handshake decisions for this cycle.
    always_comb begin
        full       = (count_q == CNT_DEPTH);
        empty      = (count_q == '0);
        in_ready   = !full && !flush;
        out_valid  = !empty;
        pc_aligned = (in_pc[1:0] == 2'b00);
        push_try   = in_valid && in_ready;
        do_push    = push_try && pc_aligned;
        bad_push   = push_try && !pc_aligned;
        do_pop     = out_valid && out_ready && !flush;
        count      = count_q;
        misalign_err = misalign_q;
    end

    // Head entry falls through to decode; an empty queue shows a NOP at PC 0.
    always_comb begin
        out_pc    = 32'h0;
        out_instr = NOP_INSTR;
        if (!empty) begin
            out_pc    = pc_mem[rd_ptr];
            out_instr = instr_mem[rd_ptr];
        end
    end

    // Storage array is written on accepted pushes only and never cleared.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
        end
    end

    // Pointers, occupancy and the sticky misalign flag; reset beats flush.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
            if (bad_push) begin
                misalign_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: each task drives one scenario and checks
// outputs against hand-computed values one time unit after the clock edge.
module tb_fetch_queue;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic        misalign_err;

    int total = 0;
    int bad   = 0;

    fetch_queue #(.DEPTH(4), .NOP_INSTR(NOP)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_pc(in_pc),
        .in_instr(in_instr),
        .in_ready(in_ready),
        .flush(flush),
        .out_valid(out_valid),
        .out_pc(out_pc),
        .out_instr(out_instr),
        .out_ready(out_ready),
        .count(count),
        .full(full),
        .empty(empty),
        .misalign_err(misalign_err)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word tagged with its PC so data and order can be checked.
    function automatic logic [31:0] tag(input logic [31:0] pc);
        return 32'hA000_0000 | pc;
    endfunction

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a fetch-stage request (data word derived from the PC).
    task automatic drive_push(input logic v, input logic [31:0] pc);
        in_valid = v;
        in_pc    = pc;
        in_instr = tag(pc);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive_push(1'b0, 32'h0);
        step();
        total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", count); end
        total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty got=%b want=1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("[TB] FAIL reset_full got=%b want=0", full); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_out_pc got=%h want=0", out_pc); end
        total++; if (out_instr !== NOP) begin bad++; $display("[TB] FAIL reset_out_instr got=%h want=%h", out_instr, NOP); end
        total++; if (misalign_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_misalign got=%b want=0", misalign_err); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_push(1'b1, 32'(4 * i));
            step();
            total++; if (count !== 3'(i + 1)) begin bad++; $display("[TB] FAIL fill_count[%0d] got=%0d want=%0d", i, count, i + 1); end
            total++; if (out_pc !== 32'h0) begin bad++; $display("[TB] FAIL fill_head[%0d] got=%h want=0", i, out_pc); end
        end
        total++; if (full !== 1'b1) begin bad++; $display("[TB] FAIL fill_full got=%b want=1", full); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL fill_in_ready got=%b want=0", in_ready); end
        drive_push(1'b1, 32'h10);
        step();
        total++; if (count !== 3'd4) begin bad++; $display("[TB] FAIL fill_fifth_count got=%0d want=4", count); end
        total++; if (out_pc !== 32'h0) begin bad++; $display("[TB] FAIL fill_fifth_head got=%h want=0", out_pc); end
        total++; if (out_instr !== tag(32'h0)) begin bad++; $display("[TB] FAIL fill_head_instr got=%h want=%h", out_instr, tag(32'h0)); end
        drive_push(1'b0, 32'h0);
    endtask

    task automatic test_drain();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            // On the first pop the queue is full, so a concurrent push must be refused.
            if (i == 0) drive_push(1'b1, 32'h80);
            else        drive_push(1'b0, 32'h0);
            total++; if (out_pc !== 32'(4 * i)) begin bad++; $display("[TB] FAIL drain_pc[%0d] got=%h want=%h", i, out_pc, 32'(4 * i)); end
            total++; if (out_instr !== tag(32'(4 * i))) begin bad++; $display("[TB] FAIL drain_instr[%0d] got=%h want=%h", i, out_instr, tag(32'(4 * i))); end
            step();
            total++; if (count !== 3'(3 - i)) begin bad++; $display("[TB] FAIL drain_count[%0d] got=%0d want=%0d", i, count, 3 - i); end
        end
        total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL drain_empty got=%b want=1", empty); end
        total++; if (out_instr !== NOP) begin bad++; $display("[TB] FAIL drain_nop got=%h want=%h", out_instr, NOP); end
        total++; if (out_pc !== 32'h0) begin bad++; $display("[TB] FAIL drain_pc_zero got=%h want=0", out_pc); end
        step();
        total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL empty_pop_count got=%0d want=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL empty_pop_valid got=%b want=0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_streaming();
        logic [31:0] head;
        out_ready = 1'b0;
        drive_push(1'b1, 32'h100);
        step();
        total++; if (count !== 3'd1) begin bad++; $display("[TB] FAIL stream_prime got=%0d want=1", count); end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            head = 32'h100 + 32'(4 * k);
            drive_push(1'b1, head + 32'h4);
            total++; if (out_pc !== head) begin bad++; $display("[TB] FAIL stream_pc[%0d] got=%h want=%h", k, out_pc, head); end
            total++; if (out_instr !== tag(head)) begin bad++; $display("[TB] FAIL stream_instr[%0d] got=%h want=%h", k, out_instr, tag(head)); end
            step();
            total++; if (count !== 3'd1) begin bad++; $display("[TB] FAIL stream_count[%0d] got=%0d want=1", k, count); end
        end
        total++; if (out_pc !== 32'h128) begin bad++; $display("[TB] FAIL stream_last got=%h want=128", out_pc); end
        drive_push(1'b0, 32'h0);
        step();
        total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL stream_empty got=%b want=1", empty); end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_push(1'b1, 32'(4 * i));
            step();
        end
        total++; if (count !== 3'd3) begin bad++; $display("[TB] FAIL flush_setup got=%0d want=3", count); end
        drive_push(1'b1, 32'h20);
        flush = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL flush_in_ready got=%b want=0", in_ready); end
        step();
        flush = 1'b0;
        drive_push(1'b0, 32'h0);
        total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL flush_count got=%0d want=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_valid got=%b want=0", out_valid); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_no_20 got=%b want=0 pc=%h", out_valid, out_pc); end
        drive_push(1'b1, 32'h30);
        step();
        drive_push(1'b0, 32'h0);
        total++; if (out_pc !== 32'h30) begin bad++; $display("[TB] FAIL flush_restart got=%h want=30", out_pc); end
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_misalign();
        out_ready = 1'b0;
        drive_push(1'b1, 32'h40);
        step();
        drive_push(1'b1, 32'h102);
        step();
        drive_push(1'b0, 32'h0);
        total++; if (misalign_err !== 1'b1) begin bad++; $display("[TB] FAIL misalign_set got=%b want=1", misalign_err); end
        total++; if (count !== 3'd1) begin bad++; $display("[TB] FAIL misalign_count got=%0d want=1", count); end
        total++; if (out_pc !== 32'h40) begin bad++; $display("[TB] FAIL misalign_head got=%h want=40", out_pc); end
        step();
        total++; if (misalign_err !== 1'b1) begin bad++; $display("[TB] FAIL misalign_sticky got=%b want=1", misalign_err); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++; if (misalign_err !== 1'b0) begin bad++; $display("[TB] FAIL misalign_flush_clr got=%b want=0", misalign_err); end
        drive_push(1'b1, 32'h201);
        step();
        drive_push(1'b0, 32'h0);
        total++; if (misalign_err !== 1'b1) begin bad++; $display("[TB] FAIL misalign_set2 got=%b want=1", misalign_err); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (misalign_err !== 1'b0) begin bad++; $display("[TB] FAIL misalign_rst_clr got=%b want=0", misalign_err); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive_push(1'b1, 32'h50);
        step();
        drive_push(1'b1, 32'h54);
        step();
        total++; if (count !== 3'd2) begin bad++; $display("[TB] FAIL rstmid_setup got=%0d want=2", count); end
        drive_push(1'b1, 32'h58);
        out_ready = 1'b1;
        rst = 1'b1;
        step();
        total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL rstmid_count got=%0d want=0", count); end
        total++; if (out_instr !== NOP) begin bad++; $display("[TB] FAIL rstmid_nop got=%h want=%h", out_instr, NOP); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_in_ready got=%b want=1", in_ready); end
        rst = 1'b0;
        drive_push(1'b0, 32'h0);
        out_ready = 1'b0;
        step();
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_streaming();
        test_flush();
        test_misalign();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of queue entries (power of two, minimum 2).
REQ-002 The block SHALL have parameter NOP_INSTR, default 32'h00000013, giving the instruction driven when the queue is empty.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  the fetch stage presents an instruction/PC pair.
REQ-006 in_pc  input  32  address of the presented instruction.
REQ-007 in_instr  input  32  presented instruction word.
REQ-008 in_ready  output  1  the queue accepts a push this cycle.
REQ-009 flush  input  1  redirect (branch taken, jal, jalr): discard all queued entries.
REQ-010 out_valid  output  1  head entry available to decode.
REQ-011 out_pc  output  32  PC of the head entry.
REQ-012 out_instr  output  32  instruction of the head entry.
REQ-013 out_ready  input  1  decode consumes the head entry this cycle.
REQ-014 count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-015 full, empty  output  1 each  count==DEPTH and count==0 respectively.
REQ-016 misalign_err  output  1  sticky flag: a push with in_pc[1:0]!=0 was rejected.

Function
REQ-017 The queue SHALL be a first-word-fall-through FIFO built from write pointer, read pointer and occupancy counter; the pointers SHALL wrap from DEPTH-1 to 0.
REQ-018 in_ready SHALL equal !full && !flush, combinationally.
REQ-019 A push SHALL occur when in_valid && in_ready && in_pc[1:0]==2'b00; the entry is visible at out_* after the same clock edge (1-cycle push-to-output latency).
REQ-020 When in_valid && in_ready && in_pc[1:0]!=0, the entry SHALL NOT be written and misalign_err SHALL be set on the next edge.
REQ-021 out_valid SHALL equal !empty; out_pc and out_instr SHALL show the head entry when out_valid=1.
REQ-022 When empty, out_instr SHALL be NOP_INSTR and out_pc SHALL be 32'h0.
REQ-023 A pop SHALL occur when out_valid && out_ready && !flush; the read pointer advances on that edge.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and advance both pointers; this is legal at any occupancy except full, where no push is possible (in_ready=0).
REQ-025 A pop on an empty queue (out_ready=1, out_valid=0) SHALL have no effect.
REQ-026 flush SHALL take priority over push and pop: on the edge with flush=1, pointers and count SHALL go to 0, the incoming entry SHALL be discarded, and misalign_err SHALL clear.
REQ-027 count SHALL never exceed DEPTH nor underflow below 0.
REQ-028 Stored data SHALL not be reset; only pointers, count and flags are.

Reset
REQ-029 On a clock edge with rst=1: pointers=0, count=0, empty=1, full=0, out_valid=0, out_pc=0, out_instr=NOP_INSTR, misalign_err=0; in_ready=1 while rst=1 and flush=0.
REQ-030 rst SHALL take priority over flush, push and pop; reset mid-operation SHALL discard all entries.

Verification
REQ-031 Fill: with out_ready=0, push PCs 0x0,0x4,0x8,0xC -> count=4, full=1, in_ready=0; a fifth push is ignored, and out_pc=0x0 throughout.
REQ-032 Drain order: from the full state, out_ready=1 for 4 cycles -> out_pc sequence 0x0,0x4,0x8,0xC; then empty=1, out_instr=0x00000013.
REQ-033 Streaming: push and pop every cycle for 10 cycles starting at count=1 -> count stays 1; pointers wrap correctly and data order is preserved.
REQ-034 Flush: with count=3 and a concurrent push (PC 0x20), assert flush for one cycle -> the next cycle count=0, out_valid=0, and PC 0x20 is never output.
REQ-035 Misalign: push in_pc=0x102 -> no entry written, misalign_err=1 on the next cycle, count unchanged; the flag clears after flush or rst.
REQ-036 Reset mid-stream: rst=1 with count=2 and push/pop active -> the next cycle count=0, out_instr=0x00000013, in_ready=1.
